// File: rtl/core_wb_arbiter_if.sv
// Write-back bus between the five execution units, the arbiter and the register file.
// The master modport is the unit/regfile side; the slave modport is the arbiter.
interface core_wb_arbiter_if;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned MASK_W = 16;

    logic              alu_a_valid;
    logic [REG_W-1:0]  alu_a_rd;
    logic [WORD_W-1:0] alu_a_value;
    logic              alu_a_stall;

    logic              alu_b_valid;
    logic [REG_W-1:0]  alu_b_rd;
    logic [WORD_W-1:0] alu_b_value;
    logic              alu_b_stall;

    logic              mul_valid;
    logic [REG_W-1:0]  mul_rd;
    logic [WORD_W-1:0] mul_value;
    logic              mul_stall;

    logic              ldst_valid;
    logic [REG_W-1:0]  ldst_rd;
    logic [WORD_W-1:0] ldst_value;
    logic              ldst_stall;

    logic              branch_valid;
    logic [REG_W-1:0]  branch_rd;
    logic [WORD_W-1:0] branch_value;
    logic              branch_stall;

    logic              wr_a_en;
    logic [REG_W-1:0]  wr_a_r;
    logic [WORD_W-1:0] wr_a_value;
    logic              wr_b_en;
    logic [REG_W-1:0]  wr_b_r;
    logic [WORD_W-1:0] wr_b_value;

    logic [MASK_W-1:0] wb_pending;
    logic              wb_stall_branch;

    modport master (
        output alu_a_valid, alu_a_rd, alu_a_value,
        output alu_b_valid, alu_b_rd, alu_b_value,
        output mul_valid, mul_rd, mul_value,
        output ldst_valid, ldst_rd, ldst_value,
        output branch_valid, branch_rd, branch_value,
        input  alu_a_stall, alu_b_stall, mul_stall, ldst_stall, branch_stall,
        input  wr_a_en, wr_a_r, wr_a_value, wr_b_en, wr_b_r, wr_b_value,
        input  wb_pending, wb_stall_branch
    );

    modport slave (
        input  alu_a_valid, alu_a_rd, alu_a_value,
        input  alu_b_valid, alu_b_rd, alu_b_value,
        input  mul_valid, mul_rd, mul_value,
        input  ldst_valid, ldst_rd, ldst_value,
        input  branch_valid, branch_rd, branch_value,
        output alu_a_stall, alu_b_stall, mul_stall, ldst_stall, branch_stall,
        output wr_a_en, wr_a_r, wr_a_value, wr_b_en, wr_b_r, wr_b_value,
        output wb_pending, wb_stall_branch
    );
endinterface

// File: rtl/core_wb_arbiter.sv
// Write-back arbiter: grants up to two of five unit results per cycle onto the two
// register-file write ports; ALUs have fixed priority, long units rotate round-robin.
module core_wb_arbiter (
    input  logic               clk,
    input  logic               rst,
    core_wb_arbiter_if.slave   wb
);
    localparam int unsigned N_UNITS = 5;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned MASK_W  = 16;

    localparam logic [2:0] U_ALU_A  = 3'd0;
    localparam logic [2:0] U_ALU_B  = 3'd1;
    localparam logic [2:0] U_MUL    = 3'd2;
    localparam logic [2:0] U_LDST   = 3'd3;
    localparam logic [2:0] U_BRANCH = 3'd4;

    typedef enum logic [1:0] {RR_MUL = 2'd0, RR_LDST = 2'd1, RR_BRANCH = 2'd2} rr_e;

    rr_e               rr_q, rr_d;
    logic              alu_yield_q, alu_yield_d;
    logic              wr_a_en_q, wr_a_en_d, wr_b_en_q, wr_b_en_d;
    logic [REG_W-1:0]  wr_a_r_q, wr_a_r_d, wr_b_r_q, wr_b_r_d;
    logic [WORD_W-1:0] wr_a_value_q, wr_a_value_d, wr_b_value_q, wr_b_value_d;

    logic [N_UNITS-1:0] valid, grant, stall;
    logic [REG_W-1:0]   rd    [N_UNITS];
    logic [WORD_W-1:0]  value [N_UNITS];
    logic [2:0]         ord   [N_UNITS];
    logic [MASK_W-1:0]  pending;
    logic               any_long, yield_now, long_granted;
    logic [1:0]         n_grant;
    logic [2:0]         sel_a, sel_b, last_long;

    always_comb begin
        valid    = {wb.branch_valid, wb.ldst_valid, wb.mul_valid, wb.alu_b_valid, wb.alu_a_valid};
        rd[0]    = wb.alu_a_rd;    value[0] = wb.alu_a_value;
        rd[1]    = wb.alu_b_rd;    value[1] = wb.alu_b_value;
        rd[2]    = wb.mul_rd;      value[2] = wb.mul_value;
        rd[3]    = wb.ldst_rd;     value[3] = wb.ldst_value;
        rd[4]    = wb.branch_rd;   value[4] = wb.branch_value;
    end

    // Priority walk: alu_a, alu_b, then long units starting at rr; skip same-rd collisions.
    always_comb begin
        any_long     = |valid[4:2];
        yield_now    = alu_yield_q && any_long;
        ord[0]       = U_ALU_A;
        ord[1]       = U_ALU_B;
        unique case (rr_q)
            RR_LDST:   begin ord[2] = U_LDST;   ord[3] = U_BRANCH; ord[4] = U_MUL;    end
            RR_BRANCH: begin ord[2] = U_BRANCH; ord[3] = U_MUL;    ord[4] = U_LDST;   end
            default:   begin ord[2] = U_MUL;    ord[3] = U_LDST;   ord[4] = U_BRANCH; end
        endcase
        grant        = '0;
        n_grant      = 2'd0;
        sel_a        = U_ALU_A;
        sel_b        = U_ALU_A;
        last_long    = U_MUL;
        long_granted = 1'b0;
        for (int k = 0; k < int'(N_UNITS); k++) begin
            if (!rst && valid[ord[k]] && !(ord[k] == U_ALU_B && yield_now) && n_grant != 2'd2) begin
                if (n_grant == 2'd0) begin
                    grant[ord[k]] = 1'b1;
                    sel_a         = ord[k];
                    n_grant       = 2'd1;
                end else if (rd[ord[k]] != rd[sel_a]) begin
                    grant[ord[k]] = 1'b1;
                    sel_b         = ord[k];
                    n_grant       = 2'd2;
                end
                if (grant[ord[k]] && ord[k] >= U_MUL) begin
                    long_granted = 1'b1;
                    last_long    = ord[k];
                end
            end
        end
    end

    // Stalls, pending mask, and next-state for rr, alu_yield and the write ports.
    always_comb begin
        stall   = valid & ~grant & {N_UNITS{~rst}};
        pending = '0;
        for (int u = 0; u < int'(N_UNITS); u++) begin
            if (stall[u]) pending[rd[u]] = 1'b1;
        end

        rr_d = rr_q;
        if (long_granted) begin
            unique case (last_long)
                U_MUL:   rr_d = RR_LDST;
                U_LDST:  rr_d = RR_BRANCH;
                default: rr_d = RR_MUL;
            endcase
        end

        alu_yield_d = alu_yield_q;
        if (!any_long)                alu_yield_d = 1'b0;
        else if (valid[0] && valid[1]) alu_yield_d = ~alu_yield_q;

        wr_a_en_d    = (n_grant != 2'd0);
        wr_a_r_d     = rd[sel_a];
        wr_a_value_d = value[sel_a];
        wr_b_en_d    = (n_grant == 2'd2);
        wr_b_r_d     = rd[sel_b];
        wr_b_value_d = value[sel_b];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q        <= RR_MUL;
            alu_yield_q <= 1'b0;
            wr_a_en_q   <= 1'b0;
            wr_b_en_q   <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            alu_yield_q <= alu_yield_d;
            wr_a_en_q   <= wr_a_en_d;
            wr_b_en_q   <= wr_b_en_d;
        end
    end

    // Address/data need no reset: they are ignored while the enables are low.
    always_ff @(posedge clk) begin
        wr_a_r_q     <= wr_a_r_d;
        wr_a_value_q <= wr_a_value_d;
        wr_b_r_q     <= wr_b_r_d;
        wr_b_value_q <= wr_b_value_d;
    end

    assign wb.alu_a_stall     = stall[0];
    assign wb.alu_b_stall     = stall[1];
    assign wb.mul_stall       = stall[2];
    assign wb.ldst_stall      = stall[3];
    assign wb.branch_stall    = stall[4];
    assign wb.wb_pending      = pending;
    assign wb.wb_stall_branch = stall[4];
    assign wb.wr_a_en         = wr_a_en_q;
    assign wb.wr_a_r          = wr_a_r_q;
    assign wb.wr_a_value      = wr_a_value_q;
    assign wb.wr_b_en         = wr_b_en_q;
    assign wb.wr_b_r          = wr_b_r_q;
    assign wb.wr_b_value      = wr_b_value_q;
endmodule

// File: tb/tb_core_wb_arbiter.sv
// Directed bench for core_wb_arbiter: combinational stalls checked in-cycle, write-port
// results queued as expectations and popped by a monitor one cycle later.
module tb_core_wb_arbiter;
    typedef struct {
        int          cyc;
        logic        en_a;
        logic [3:0]  ra;
        logic [31:0] va;
        logic        en_b;
        logic [3:0]  rb;
        logic [31:0] vb;
    } wr_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_pass;
    int   n_total;
    wr_t  exp_q[$];
    wr_t  m;

    core_wb_arbiter_if bus();

    core_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic wr_t mk(input logic ea, input logic [3:0] ra, input logic [31:0] va,
                               input logic eb, input logic [3:0] rb, input logic [31:0] vb);
        wr_t w;
        w.cyc = 0; w.en_a = ea; w.ra = ra; w.va = va; w.en_b = eb; w.rb = rb; w.vb = vb;
        return w;
    endfunction

    task automatic drive(input logic r, input logic [4:0] v,
                         input logic [4:0][3:0] rds, input logic [4:0][31:0] vals);
        rst = r;
        bus.alu_a_valid  = v[0]; bus.alu_a_rd  = rds[0]; bus.alu_a_value  = vals[0];
        bus.alu_b_valid  = v[1]; bus.alu_b_rd  = rds[1]; bus.alu_b_value  = vals[1];
        bus.mul_valid    = v[2]; bus.mul_rd    = rds[2]; bus.mul_value    = vals[2];
        bus.ldst_valid   = v[3]; bus.ldst_rd   = rds[3]; bus.ldst_value   = vals[3];
        bus.branch_valid = v[4]; bus.branch_rd = rds[4]; bus.branch_value = vals[4];
    endtask

    // One cycle: drive after the edge, check combinational outputs mid-cycle, queue the write.
    task automatic step(input logic r, input logic [4:0] v,
                        input logic [4:0][3:0] rds, input logic [4:0][31:0] vals,
                        input logic [4:0] e_stall, input logic [15:0] e_pend, input wr_t e_wr);
        wr_t w;
        logic [4:0] act;
        @(posedge clk);
        #1;
        drive(r, v, rds, vals);
        @(negedge clk);
        act = {bus.branch_stall, bus.ldst_stall, bus.mul_stall, bus.alu_b_stall, bus.alu_a_stall};
        chk("stall", 32'(act), 32'(e_stall));
        chk("wb_pending", 32'(bus.wb_pending), 32'(e_pend));
        chk("wb_stall_branch", 32'(bus.wb_stall_branch), 32'(e_stall[4]));
        w = e_wr;
        w.cyc = cyc + 1;
        exp_q.push_back(w);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            m = exp_q.pop_front();
            chk("wr_a_en", 32'(bus.wr_a_en), 32'(m.en_a));
            if (m.en_a) begin
                chk("wr_a_r", 32'(bus.wr_a_r), 32'(m.ra));
                chk("wr_a_value", bus.wr_a_value, m.va);
            end
            chk("wr_b_en", 32'(bus.wr_b_en), 32'(m.en_b));
            if (m.en_b) begin
                chk("wr_b_r", 32'(bus.wr_b_r), 32'(m.rb));
                chk("wr_b_value", bus.wr_b_value, m.vb);
            end
        end
    end

    initial begin
        logic [4:0][3:0]  rd_z, rd_alu, rd_same7, rd_mid, rd_long, rd_all, rd_five;
        logic [4:0][31:0] v_z, v_alu, v_same7, v_mid, v_long, v_all;
        wr_t none;
        n_pass  = 0;
        n_total = 0;
        none    = mk(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
        rd_z    = '0;
        v_z     = '0;
        rd_alu  = {4'd0, 4'd0, 4'd0, 4'd5, 4'd3};
        v_alu   = {32'h0, 32'h0, 32'h0, 32'h22, 32'h11};
        rd_same7 = {4'd0, 4'd0, 4'd7, 4'd0, 4'd7};
        v_same7 = {32'h0, 32'h0, 32'h77, 32'h0, 32'hAA};
        rd_mid  = {4'd0, 4'd0, 4'd9, 4'd2, 4'd1};
        v_mid   = {32'h0, 32'h0, 32'h99, 32'hB2, 32'hA1};
        rd_long = {4'd8, 4'd6, 4'd4, 4'd0, 4'd0};
        v_long  = {32'h88, 32'h66, 32'h44, 32'h0, 32'h0};
        rd_all  = {4'd8, 4'd6, 4'd4, 4'd2, 4'd1};
        v_all   = {32'h88, 32'h66, 32'h44, 32'hB2, 32'hA1};
        rd_five = {4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
        drive(1'b1, 5'b0, rd_z, v_z);

        // Reset: valid inputs are ignored, no stalls or pending bits.
        step(1'b1, 5'b11111, rd_all, v_all, 5'b00000, 16'h0000, none);
        step(1'b1, 5'b00000, rd_z, v_z, 5'b00000, 16'h0000, none);

        // ALUs only, then an idle cycle.
        step(1'b0, 5'b00011, rd_alu, v_alu, 5'b00000, 16'h0000, mk(1, 4'd3, 32'h11, 1, 4'd5, 32'h22));
        step(1'b0, 5'b00000, rd_z, v_z, 5'b00000, 16'h0000, none);

        // Same destination: mul loses to alu_a, then wins alone (rr moves to ldst).
        step(1'b0, 5'b00101, rd_same7, v_same7, 5'b00100, 16'h0080, mk(1, 4'd7, 32'hAA, 0, 4'd0, 32'h0));
        step(1'b0, 5'b00100, rd_same7, v_same7, 5'b00000, 16'h0000, mk(1, 4'd7, 32'h77, 0, 4'd0, 32'h0));

        // Reset mid-operation: mul stalled behind both ALUs, then reset drops everything.
        step(1'b0, 5'b00111, rd_mid, v_mid, 5'b00100, 16'h0200, mk(1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2));
        step(1'b1, 5'b00111, rd_mid, v_mid, 5'b00000, 16'h0000, none);

        // Round robin from rr = mul after reset.
        step(1'b0, 5'b11100, rd_long, v_long, 5'b10000, 16'h0100, mk(1, 4'd4, 32'h44, 1, 4'd6, 32'h66));
        step(1'b0, 5'b11100, rd_long, v_long, 5'b01000, 16'h0040, mk(1, 4'd8, 32'h88, 1, 4'd4, 32'h44));
        step(1'b0, 5'b11100, rd_long, v_long, 5'b00100, 16'h0010, mk(1, 4'd6, 32'h66, 1, 4'd8, 32'h88));

        // Fairness: alu_b yields every other cycle to the rotating long unit.
        step(1'b0, 5'b11111, rd_all, v_all, 5'b11100, 16'h0150, mk(1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2));
        step(1'b0, 5'b11111, rd_all, v_all, 5'b11010, 16'h0144, mk(1, 4'd1, 32'hA1, 1, 4'd4, 32'h44));
        step(1'b0, 5'b11111, rd_all, v_all, 5'b11100, 16'h0150, mk(1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2));
        step(1'b0, 5'b11111, rd_all, v_all, 5'b10110, 16'h0114, mk(1, 4'd1, 32'hA1, 1, 4'd6, 32'h66));
        step(1'b0, 5'b11111, rd_all, v_all, 5'b11100, 16'h0150, mk(1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2));
        step(1'b0, 5'b11111, rd_all, v_all, 5'b01110, 16'h0054, mk(1, 4'd1, 32'hA1, 1, 4'd8, 32'h88));

        // All five share one destination: single grant.
        step(1'b0, 5'b11111, rd_five, v_all, 5'b11110, 16'h0020, mk(1, 4'd5, 32'hA1, 0, 4'd0, 32'h0));
        step(1'b0, 5'b00000, rd_z, v_z, 5'b00000, 16'h0000, none);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("expect_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
